// File: rtl/viterbi_channel_injector.sv
// Corrupting channel between convolutional encoder and Viterbi decoder: forwards W-bit
// symbols with one cycle of latency, XORing an error mask on selected symbols.
module viterbi_channel_injector #(
    parameter int unsigned W    = 2,
    parameter int unsigned CW   = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    cfg_mode,
    input  logic [W-1:0]  cfg_mask,
    input  logic [3:0]    cfg_period_log2,
    input  logic [7:0]    cfg_burst_len,
    input  logic [15:0]   cfg_threshold,
    input  logic [CW-1:0] cfg_window,
    input  logic          clear_i,
    input  logic          valid_i,
    input  logic [W-1:0]  sym_i,
    output logic          valid_o,
    output logic [W-1:0]  sym_o,
    output logic          err_flag_o,
    output logic [CW-1:0] sym_ct_o,
    output logic [CW-1:0] bit_err_ct_o,
    output logic          sat_o
);

    localparam logic [CW-1:0] CtMax = '1;
    localparam int unsigned   PW    = $clog2(W + 1);

    typedef enum logic [1:0] {ModeOff, ModePeriodic, ModeRandom, ModeSingle} mode_e;

    mode_e         mode;
    logic          valid_q, valid_d, err_q, err_d, sat_q, sat_d;
    logic [W-1:0]  sym_q, sym_d, inj;
    logic [CW-1:0] sym_ct_q, sym_ct_d, bit_ct_q, bit_ct_d;
    logic [CW:0]   bit_sum;
    logic [7:0]    phase_q, phase_d, phase_mask;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          armed_q, armed_d, armed_eff, entry, en, hit, fb;
    logic [1:0]    prev_mode_q;
    logic [3:0]    p;
    logic [PW-1:0] pop;

    assign mode = mode_e'(cfg_mode);

    always_comb begin
        en         = (cfg_window == '0) || (sym_ct_q < cfg_window);
        p          = (cfg_period_log2 > 4'd8) ? 4'd8 : cfg_period_log2;
        phase_mask = 8'((9'd1 << p) - 9'd1);
        // Entering SINGLE re-arms in the same cycle so that cycle's symbol can fire.
        entry      = (mode == ModeSingle) && (prev_mode_q != 2'd3);
        armed_eff  = armed_q | entry;
        fb         = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

        hit = 1'b0;
        unique case (mode)
            ModeOff:      hit = 1'b0;
            ModePeriodic: hit = (phase_q < cfg_burst_len);
            ModeRandom:   hit = (lfsr_q < cfg_threshold);
            ModeSingle:   hit = armed_eff;
        endcase
        inj = (valid_i && en && !clear_i && hit) ? cfg_mask : '0;

        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + PW'(inj[i]);
        end
        bit_sum = {1'b0, bit_ct_q} + (CW + 1)'(pop);

        valid_d   = valid_i;
        err_d     = valid_i && (inj != '0);
        sym_d     = valid_i ? (sym_i ^ inj) : sym_q;
        sym_ct_d  = sym_ct_q;
        bit_ct_d  = bit_ct_q;
        sat_d     = sat_q;
        phase_d   = phase_q;
        lfsr_d    = lfsr_q;
        armed_d   = armed_eff;

        if (clear_i) begin
            err_d    = 1'b0;
            sym_ct_d = '0;
            bit_ct_d = '0;
            sat_d    = 1'b0;
            phase_d  = '0;
            lfsr_d   = SEED;
            armed_d  = 1'b1;
        end else begin
            if (cfg_mode != prev_mode_q) begin
                phase_d = '0;
            end else if (valid_i) begin
                phase_d = (phase_q + 8'd1) & phase_mask;
            end
            if (valid_i) begin
                lfsr_d   = {lfsr_q[14:0], fb};
                sym_ct_d = (sym_ct_q == CtMax) ? sym_ct_q : sym_ct_q + CW'(1);
                bit_ct_d = (bit_sum > {1'b0, CtMax}) ? CtMax : bit_sum[CW-1:0];
                if (en && mode == ModeSingle && armed_eff) begin
                    armed_d = 1'b0;
                end
            end
            sat_d = sat_q | (sym_ct_d == CtMax) | (bit_ct_d == CtMax);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            sym_q       <= '0;
            err_q       <= 1'b0;
            sym_ct_q    <= '0;
            bit_ct_q    <= '0;
            sat_q       <= 1'b0;
            phase_q     <= '0;
            lfsr_q      <= SEED;
            armed_q     <= 1'b1;
            prev_mode_q <= 2'd0;
        end else begin
            valid_q     <= valid_d;
            sym_q       <= sym_d;
            err_q       <= err_d;
            sym_ct_q    <= sym_ct_d;
            bit_ct_q    <= bit_ct_d;
            sat_q       <= sat_d;
            phase_q     <= phase_d;
            lfsr_q      <= lfsr_d;
            armed_q     <= armed_d;
            prev_mode_q <= cfg_mode;
        end
    end

    assign valid_o      = valid_q;
    assign sym_o        = sym_q;
    assign err_flag_o   = err_q;
    assign sym_ct_o     = sym_ct_q;
    assign bit_err_ct_o = bit_ct_q;
    assign sat_o        = sat_q;

endmodule

// File: tb/tb_viterbi_channel_injector.sv
// Randomised and directed bench for viterbi_channel_injector against a behavioural channel model.
module tb_viterbi_channel_injector;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [1:0]  cfg_mask = '0;
    logic [3:0]  cfg_period_log2 = '0;
    logic [7:0]  cfg_burst_len = '0;
    logic [15:0] cfg_threshold = '0;
    logic [15:0] cfg_window = '0;
    logic        clear_i = 1'b0, valid_i = 1'b0;
    logic [1:0]  sym_i = '0;
    logic [3:0]  win4;

    logic        valid_o, err_flag_o, sat_o;
    logic [1:0]  sym_o;
    logic [15:0] sym_ct_o, bit_err_ct_o;
    logic        valid2, err2, sat2;
    logic [1:0]  sym2;
    logic [3:0]  sym_ct2, bit_ct2;

    int tests = 0;
    int fails = 0;

    assign win4 = cfg_window[3:0];

    always #5 clk = ~clk;

    viterbi_channel_injector #(.W(2), .CW(16), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
        .cfg_period_log2(cfg_period_log2), .cfg_burst_len(cfg_burst_len),
        .cfg_threshold(cfg_threshold), .cfg_window(cfg_window), .clear_i(clear_i),
        .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o),
        .err_flag_o(err_flag_o), .sym_ct_o(sym_ct_o), .bit_err_ct_o(bit_err_ct_o), .sat_o(sat_o)
    );

    viterbi_channel_injector #(.W(2), .CW(4), .SEED(SEED)) dut_small (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
        .cfg_period_log2(cfg_period_log2), .cfg_burst_len(cfg_burst_len),
        .cfg_threshold(cfg_threshold), .cfg_window(win4), .clear_i(clear_i),
        .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid2), .sym_o(sym2),
        .err_flag_o(err2), .sym_ct_o(sym_ct2), .bit_err_ct_o(bit_ct2), .sat_o(sat2)
    );

    // Behavioural channel state (CW = 16 instance)
    int unsigned m_sym_ct, m_bit_ct, m_phase, m_lfsr, m_prev;
    bit          m_armed, m_sat, e_valid, e_err;
    int unsigned e_sym;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sym_ct = 0; m_bit_ct = 0; m_phase = 0; m_lfsr = SEED; m_prev = 0;
        m_armed = 1; m_sat = 0; e_valid = 0; e_err = 0; e_sym = 0;
    endtask

    task automatic model_step();
        int unsigned period, inj, pop, mode, fb;
        bit en, armed_eff;
        mode      = cfg_mode;
        period    = 1 << ((cfg_period_log2 > 8) ? 8 : cfg_period_log2);
        en        = (cfg_window == 0) || (m_sym_ct < cfg_window);
        armed_eff = m_armed || (mode == 3 && m_prev != 3);
        inj = 0;
        if (!clear_i && valid_i && en) begin
            if (mode == 1 && m_phase < cfg_burst_len) inj = cfg_mask;
            if (mode == 2 && m_lfsr < cfg_threshold) inj = cfg_mask;
            if (mode == 3 && armed_eff) inj = cfg_mask;
        end
        pop     = (inj & 1) + ((inj >> 1) & 1);
        e_valid = valid_i;
        e_err   = valid_i && inj != 0;
        if (valid_i) e_sym = sym_i ^ inj;
        if (clear_i) begin
            m_sym_ct = 0; m_bit_ct = 0; m_phase = 0; m_lfsr = SEED; m_armed = 1; m_sat = 0;
        end else begin
            if (mode != m_prev) m_phase = 0;
            else if (valid_i) m_phase = (m_phase + 1) % period;
            m_armed = armed_eff;
            if (valid_i) begin
                fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
                m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
                m_sym_ct = (m_sym_ct + 1 > 65535) ? 65535 : m_sym_ct + 1;
                m_bit_ct = (m_bit_ct + pop > 65535) ? 65535 : m_bit_ct + pop;
                if (en && mode == 3 && armed_eff) m_armed = 0;
            end
            if (m_sym_ct == 65535 || m_bit_ct == 65535) m_sat = 1;
        end
        m_prev = mode;
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic clr);
        @(negedge clk);
        valid_i = v; sym_i = s; clear_i = clr;
        model_step();
        @(posedge clk);
        #1;
        check("valid_o", valid_o, e_valid);
        check("sym_o", sym_o, e_sym);
        check("err_flag_o", err_flag_o, e_err);
        check("sym_ct_o", sym_ct_o, m_sym_ct);
        check("bit_err_ct_o", bit_err_ct_o, m_bit_ct);
        check("sat_o", sat_o, m_sat);
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [1:0] mask, input logic [3:0] plog,
                           input logic [7:0] burst, input logic [15:0] thr, input logic [15:0] win);
        cfg_mode = mode; cfg_mask = mask; cfg_period_log2 = plog;
        cfg_burst_len = burst; cfg_threshold = thr; cfg_window = win;
    endtask

    initial begin
        int cnt, last;
        bit seq [200];
        model_reset();
        #12;
        check("rst_valid_o", valid_o, 0);
        check("rst_sym_ct_o", sym_ct_o, 0);
        check("rst_sat_o", sat_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // OFF: clean pass-through
        set_cfg(2'd0, 2'b11, 4'd0, 8'd0, 16'd0, 16'd0);
        step(0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 2'b10, 0);
            check("off_sym", sym_o, 2'b10);
            cnt += int'(err_flag_o);
        end
        check("off_errs", cnt, 0);
        check("off_sym_ct", sym_ct_o, 20);
        check("off_bit_ct", bit_err_ct_o, 0);

        // PERIODIC 16, burst 2
        set_cfg(2'd1, 2'b01, 4'd4, 8'd2, 16'd0, 16'd0);
        step(0, 0, 1);
        for (int i = 0; i < 64; i++) begin
            step(1, 2'(i), 0);
            check("per_idx", err_flag_o, ((i % 16) < 2) ? 1 : 0);
        end
        check("per_bit_ct", bit_err_ct_o, 8);

        // PERIODIC with window
        set_cfg(2'd1, 2'b11, 4'd3, 8'd1, 16'd0, 16'd256);
        step(0, 0, 1);
        cnt = 0; last = -1;
        for (int i = 0; i < 300; i++) begin
            step(1, 2'($urandom), 0);
            if (err_flag_o) begin cnt++; last = i; end
        end
        check("win_errs", cnt, 32);
        check("win_last_lt256", (last < 256) ? 1 : 0, 1);
        check("win_bit_ct", bit_err_ct_o, 64);

        // RANDOM: threshold 0, then near-certain, then reproducibility
        set_cfg(2'd2, 2'b11, 4'd0, 8'd0, 16'd0, 16'd0);
        step(0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 2'($urandom), 0);
            cnt += int'(err_flag_o);
        end
        check("rnd0_errs", cnt, 0);
        cfg_threshold = 16'hFFFF;
        step(0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1, 2'($urandom), 0);
            cnt += int'(err_flag_o);
        end
        check("rndmax_ge998", (cnt >= 998) ? 1 : 0, 1);
        cfg_threshold = 16'h8000;
        step(0, 0, 1);
        for (int i = 0; i < 200; i++) begin
            step(1, 2'b00, 0);
            seq[i] = err_flag_o;
        end
        step(0, 0, 1);
        for (int i = 0; i < 200; i++) begin
            step(1, 2'b00, 0);
            check("rnd_repeat", err_flag_o, seq[i]);
        end

        // SINGLE and re-arm
        set_cfg(2'd3, 2'b10, 4'd0, 8'd0, 16'd0, 16'd0);
        step(0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 2'b01, 0);
            check("single_first", err_flag_o, (i == 0) ? 1 : 0);
        end
        cfg_mode = 2'd0;
        step(0, 0, 0);
        cfg_mode = 2'd3;
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 2'b01, 0);
            check("single_rearm", err_flag_o, (i == 0) ? 1 : 0);
        end

        // Randomised mix of modes, config, clear and idle cycles
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cfg_mode = 2'($urandom);
            if ($urandom_range(0, 29) == 0)
                set_cfg(cfg_mode, 2'($urandom), 4'($urandom), 8'($urandom_range(0, 20)),
                        16'($urandom), ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 3000))
                                                                   : 16'd0);
            step(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 99) == 0));
        end

        // Saturation on the 4-bit-counter instance
        set_cfg(2'd1, 2'b11, 4'd3, 8'd255, 16'd0, 16'd0);
        step(0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 2'b00, 0);
        check("small_bit_sat", bit_ct2, 15);
        check("small_sym_ct", sym_ct2, 8);
        check("small_sat", sat2, 1);
        check("small_err", err2, 1);
        step(1, 2'b01, 1);
        check("clr_small_sym_ct", sym_ct2, 0);
        check("clr_small_bit_ct", bit_ct2, 0);
        check("clr_small_sat", sat2, 0);
        check("clr_small_sym", sym2, 2'b01);
        check("clr_small_err", err2, 0);
        check("clr_small_valid", valid2, 1);

        // Asynchronous reset mid-stream
        step(1, 2'b10, 0);
        @(negedge clk);
        valid_i = 1'b1; sym_i = 2'b11; clear_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_valid_o", valid_o, 0);
        check("arst_sym_ct", sym_ct_o, 0);
        check("arst_bit_ct", bit_err_ct_o, 0);
        check("arst_sym_o", sym_o, 0);
        model_reset();
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;
        step(1, 2'b01, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/viterbi_channel_injector.md
Name: viterbi_channel_injector

Overview:
Parametrised corrupting channel placed between the convolutional encoder output and the Viterbi decoder input. Forwards each W-bit code symbol with 1-cycle latency and XORs a configurable error mask onto selected symbols. Injection modes are off, periodic burst, LFSR pseudo-random and single-shot. Keeps saturating symbol and bit-error counters, so a bench can correlate decoder output errors with the injected channel bit error rate.

Parameters:
W, 2, code symbol width in bits (2 = rate-1/2 code)
CW, 16, width of the symbol and bit-error counters
SEED, 16'hACE1, LFSR reset and clear value; must be non-zero

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
cfg_mode  input  2  0=OFF, 1=PERIODIC, 2=RANDOM, 3=SINGLE
cfg_mask  input  W  bits to invert on an injected symbol
cfg_period_log2  input  4  burst period = 2**cfg_period_log2 symbols; values >8 treated as 8
cfg_burst_len  input  8  consecutive corrupted symbols at the start of each period
cfg_threshold  input  16  RANDOM mode: inject when lfsr < cfg_threshold
cfg_window  input  CW  injection allowed only while sym_ct_o < cfg_window; 0 = unlimited
clear_i  input  1  synchronous clear of counters, phase, LFSR and single-shot arm
valid_i  input  1  sym_i valid this cycle
sym_i  input  W  encoder symbol
valid_o  output  1  sym_o valid
sym_o  output  W  possibly corrupted symbol
err_flag_o  output  1  symbol on sym_o was corrupted (non-zero mask applied)
sym_ct_o  output  CW  valid symbols accepted since reset/clear, saturating
bit_err_ct_o  output  CW  total inverted bits since reset/clear, saturating
sat_o  output  1  sticky: either counter has saturated

Behaviour:
- Reset (rst low, async): valid_o, sym_o, err_flag_o, counters, sat_o, phase = 0; lfsr = SEED; armed = 1; prev_mode = 0.
- Latency is exactly 1 cycle. On a valid_i cycle: sym_o <= sym_i ^ inj, valid_o <= 1, err_flag_o <= (inj != 0). On a non-valid cycle: valid_o <= 0, err_flag_o <= 0, sym_o holds.
- en = (cfg_window == 0) || (sym_ct_o < cfg_window). inj = 0 whenever en is 0 or the mode is OFF.
- PERIODIC: phase is an 8-bit counter that advances on each valid symbol and wraps at 2**p, where p is the clamped cfg_period_log2. inj = cfg_mask when phase < cfg_burst_len. If cfg_burst_len >= 2**p, every symbol is corrupted. If p = 0, period = 1.
- RANDOM: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances once per valid symbol in any mode. inj = cfg_mask when the lfsr value before the advance is < cfg_threshold. cfg_threshold 0 means never inject. Injection probability = cfg_threshold/65536.
- SINGLE: inj = cfg_mask on the first valid, en symbol while armed; armed then clears. armed sets again on entry into mode 3 (cfg_mode changes to 3) or on clear_i.
- Mode change: when cfg_mode != prev_mode, phase <= 0 that cycle. prev_mode is registered every cycle.
- Counters: sym_ct_o +1 per valid symbol. bit_err_ct_o += popcount(inj). Both saturate at 2**CW-1 with no wrap. sat_o is set when either counter reaches its maximum, and is cleared only by reset or clear_i.
- clear_i has priority. A symbol arriving on a clear cycle is forwarded uncorrupted (err_flag_o = 0) and is not counted. Counters, phase and sat_o go to 0, lfsr goes to SEED, armed goes to 1.
- Config inputs are sampled combinationally each cycle and need no handshake. Changing cfg_mask mid-burst takes effect on the next symbol.
- Reset asserted mid-stream: an in-flight symbol is lost and valid_o drops immediately.

Test Plan:
- Mode OFF, 20 valid symbols 2'b10 -> sym_o = 2'b10 one cycle later each time; err_flag_o never 1; sym_ct_o = 20; bit_err_ct_o = 0.
- PERIODIC, period_log2 = 4, burst_len = 2, mask = 2'b01, 64 symbols -> symbols 0,1,16,17,32,33,48,49 have bit 0 inverted; bit_err_ct_o = 8.
- PERIODIC, mask = 2'b11, window = 256, burst_len = 1, period_log2 = 3, 300 symbols -> 32 corrupted symbols, all before index 256; bit_err_ct_o = 64.
- RANDOM, threshold = 0 gives 0 errors. Threshold = 16'hFFFF, mask = 2'b11, 1000 symbols gives ≥ 998 corrupted symbols. Repeating a run after clear_i reproduces the identical error sequence.
- SINGLE, mask = 2'b10 -> only the first symbol corrupted. Switching to OFF and back to 3 re-arms it, so the next symbol is corrupted again.
- CW = 4, mask = 2'b11, all symbols injected -> bit_err_ct_o sticks at 15 and sat_o = 1. clear_i together with valid_i -> counters 0, sat_o 0, that symbol passes uncorrupted and is not counted.
